fpro_nios2_gen2_0_cpu_debug_ocimem_sched: RTL and testbench
===========================================================

Name: fpro_nios2_gen2_0_cpu_debug_ocimem_sched

Overview:
- Sysclk-domain scheduler for the single-port OCI debug RAM.
- Shares the RAM between two requesters: JTAG debug-host commands (take_action_ocimem_a/b strobes plus jdo from the debug-slave sysclk block) and a local host port (firmware or debug-monitor logic).
- Round-robin arbitration, one-outstanding-access sequencing, JTAG address auto-increment.
- Returns JTAG read data on MonDReg with the monitor_ready handshake.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, RAM/MonDReg data width; fixed at 32 for jdo decode.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- take_action_ocimem_a  in  1  JTAG address-load strobe, 1 cycle.
- take_action_ocimem_b  in  1  JTAG data-access strobe, 1 cycle.
- jdo  in  38  JTAG data word, valid with strobes.
- host_req  in  1  host request level; held until host_ack.
- host_we  in  1  host write(1)/read(0).
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  32  host write data.
- host_ack  out  1  host completion pulse, 1 cycle.
- host_rdata  out  32  host read data, valid with host_ack, held until the next host read.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, 1-cycle registered latency.
- MonDReg  out  32  JTAG read-data register.
- monitor_ready  out  1  JTAG access complete.
- jtag_ovf  out  1  sticky: JTAG command lost.

Behaviour:
- Reset (reset_n=0 at clk edge) values:
  - state=IDLE; jtag_pend=0; jtag_addr=0.
  - MonDReg=0, host_rdata=0; monitor_ready=0; jtag_ovf=0; host_ack=0.
  - ram_en=0, ram_we=0; last_grant=HOST, so JTAG wins the first tie.
  - Reset mid-access aborts it: no ack, no MonDReg update, ram_en=0 the cycle after reset.
- JTAG decode, registered on the strobe cycle:
  - ocimem_a: jtag_addr<=jdo[ADDR_W+1:2]. If jdo[35]=1, also set jtag_pend with op=READ (prefetch).
  - ocimem_b: set jtag_pend. op=WRITE with data jdo[34:3] if jdo[0]=1, else READ at jtag_addr.
  - Any strobe clears monitor_ready the next cycle.
- JTAG overflow:
  - A strobe arriving while jtag_pend=1 or a JTAG access is in flight is dropped and sets jtag_ovf.
  - Simultaneous ocimem_a and ocimem_b: a is taken, b is dropped, jtag_ovf set.
  - jtag_ovf clears only on reset.
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: if exactly one requester is pending (jtag_pend, or host_req with no ack in flight), grant it. If both, grant the one not equal to last_grant. Go to ISSUE, latching grantee, op, addr and wdata.
  - ISSUE (1 cycle): ram_en=1, ram_we=op, ram_addr/ram_wdata from the latch; last_grant<=grantee; go to CAPTURE. ram_en is 0 in every other state.
  - CAPTURE (1 cycle), by grantee:
    - JTAG read: MonDReg<=ram_rdata.
    - JTAG access (read or write): jtag_pend<=0, monitor_ready<=1 (registered), jtag_addr<=jtag_addr+1, wrapping 2^ADDR_W-1 -> 0.
    - Host: host_ack<=1 for exactly one cycle after CAPTURE; on a read, host_rdata<=ram_rdata. Host write leaves host_rdata unchanged.
    - Go to IDLE.
- Latency:
  - JTAG strobe at cycle N: jtag_pend=1 at N+1, ISSUE at N+2, CAPTURE at N+3, MonDReg/monitor_ready updated at N+4.
  - Host req sampled at N (idle): host_ack at N+3.
  - Minimum 3 cycles per access; back-to-back grants alternate under contention.
- Host port rules:
  - Host must hold host_req until host_ack. IDLE ignores host_req during the cycle host_ack is high, so no double grant.
  - Host inputs are sampled only in IDLE on grant.
- MonDReg changes only on JTAG read completion and is stable otherwise.

Test Plan:
- Reset then ocimem_a with jdo[ADDR_W+1:2]=0x10, jdo[35]=1; RAM[0x10]=0xDEADBEEF -> ram_en at N+2 with addr 0x10, MonDReg=0xDEADBEEF and monitor_ready=1 at N+4, jtag_addr=0x11.
- ocimem_b write jdo[0]=1, data 0x12345678, at jtag_addr=0xFF -> RAM[0xFF]=0x12345678, jtag_addr wraps to 0x00, MonDReg unchanged.
- host_req read of addr 0x05 asserted in the same cycle jtag_pend sets, after reset -> JTAG issued first; host ISSUE follows after JTAG CAPTURE; host_ack 1 cycle with host_rdata=RAM[0x05].
- Continuous host_req plus repeated JTAG reads -> ram_en grants alternate JTAG/HOST; neither requester waits more than one foreign access.
- Second ocimem_b while the first read is in flight, and a separate ocimem_a+ocimem_b same-cycle -> jtag_ovf=1 (sticky); only one access issued per case.
- reset_n low during CAPTURE of a host read -> no host_ack; all outputs at reset values next cycle; a fresh host_req completes normally.

Source files
------------

// File: rtl/fpro_nios2_gen2_0_cpu_debug_ocimem_sched.sv
// Sysclk-domain scheduler for the single-port OCI debug RAM.
// Arbitrates JTAG debug commands against a local host port (round-robin),
// keeps one access outstanding at a time, auto-increments the JTAG address
// and returns JTAG read data on MonDReg with the monitor_ready handshake.
module fpro_nios2_gen2_0_cpu_debug_ocimem_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  localparam logic GRANT_JTAG = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  state_t state, state_next;

  logic              jtag_pend;
  logic              jtag_op;
  logic [DATA_W-1:0] jtag_wdata;
  logic [ADDR_W-1:0] jtag_addr;
  logic              last_grant;

  logic              grant_q;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              grant_take;
  logic              grant_sel;
  logic              host_pending;
  logic              jtag_busy;
  logic              unused_jdo;

  assign unused_jdo   = ^{jdo[37:36], jdo[1]};
  assign host_pending = host_req && !host_ack;
  assign jtag_busy    = jtag_pend || ((state != IDLE) && (grant_q == GRANT_JTAG));

  assign ram_en    = (state == ISSUE);
  assign ram_we    = (state == ISSUE) && op_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // State register for the access sequencer
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and round-robin grant decision; a tie goes to whoever did not win last
  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    grant_sel  = last_grant;
    case (state)
      IDLE: begin
        if (jtag_pend && host_pending) begin
          grant_take = 1'b1;
          grant_sel  = ~last_grant;
        end else if (jtag_pend) begin
          grant_take = 1'b1;
          grant_sel  = GRANT_JTAG;
        end else if (host_pending) begin
          grant_take = 1'b1;
          grant_sel  = GRANT_HOST;
        end
        if (grant_take) state_next = ISSUE;
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // JTAG command decode, grant latching and completion bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jtag_pend     <= 1'b0;
      jtag_op       <= 1'b0;
      jtag_wdata    <= '0;
      jtag_addr     <= '0;
      last_grant    <= GRANT_HOST;
      grant_q       <= GRANT_HOST;
      op_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      MonDReg       <= '0;
      host_rdata    <= '0;
      monitor_ready <= 1'b0;
      jtag_ovf      <= 1'b0;
      host_ack      <= 1'b0;
    end else begin
      host_ack <= 1'b0;

      if (take_action_ocimem_a || take_action_ocimem_b) monitor_ready <= 1'b0;

      if (take_action_ocimem_a) begin
        if (jtag_busy) begin
          jtag_ovf <= 1'b1;
        end else begin
          jtag_addr <= jdo[ADDR_W+1:2];
          if (jdo[35]) begin
            jtag_pend <= 1'b1;
            jtag_op   <= 1'b0;
          end
        end
        if (take_action_ocimem_b) jtag_ovf <= 1'b1;
      end else if (take_action_ocimem_b) begin
        if (jtag_busy) begin
          jtag_ovf <= 1'b1;
        end else begin
          jtag_pend  <= 1'b1;
          jtag_op    <= jdo[0];
          jtag_wdata <= jdo[34:3];
        end
      end

      if (grant_take) begin
        grant_q <= grant_sel;
        if (grant_sel == GRANT_JTAG) begin
          op_q    <= jtag_op;
          addr_q  <= jtag_addr;
          wdata_q <= jtag_wdata;
        end else begin
          op_q    <= host_we;
          addr_q  <= host_addr;
          wdata_q <= host_wdata;
        end
      end

      if (state == ISSUE) last_grant <= grant_q;

      if (state == CAPTURE) begin
        if (grant_q == GRANT_JTAG) begin
          if (!op_q) MonDReg <= ram_rdata;
          jtag_pend     <= 1'b0;
          monitor_ready <= 1'b1;
          jtag_addr     <= jtag_addr + ADDR_W'(1);
        end else begin
          host_ack <= 1'b1;
          if (!op_q) host_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpro_nios2_gen2_0_cpu_debug_ocimem_sched.sv
// Self-checking bench for the OCI RAM scheduler: a RAM model on the RAM
// port, expected RAM accesses / MonDReg / host read data queued as stimulus
// is driven and popped by a monitor when the DUT produces them.
module tb_fpro_nios2_gen2_0_cpu_debug_ocimem_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_a = 1'b0;
  logic        take_b = 1'b0;
  logic [37:0] jdo = '0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_ovf;

  int compareCount = 0;
  int failCount = 0;

  logic [31:0] ram [256];
  logic [31:0] refMem [256];
  bit          ramLoaded = 1'b0;
  logic [31:0] monExp = '0;
  bit          mrPrev = 1'b0;

  logic [8:0]  accessQ [$];
  logic [31:0] monQ [$];
  logic [31:0] hostQ [$];

  fpro_nios2_gen2_0_cpu_debug_ocimem_sched dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b), .jdo(jdo),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_ovf(jtag_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] patt(int a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return 32'h5A000000 | (a * 32'h00010203);
  endfunction

  function automatic logic [37:0] jdoA(logic [7:0] addr, logic prefetch);
    logic [37:0] j;
    j = '0;
    j[9:2] = addr;
    j[35] = prefetch;
    return j;
  endfunction

  function automatic logic [37:0] jdoB(logic [31:0] data, logic wr);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    j[0] = wr;
    return j;
  endfunction

  // RAM model with one-cycle registered read latency
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= patt(i);
      ramLoaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT accesses RAM or completes
  always @(negedge clk) begin
    if (!reset_n) begin
      mrPrev <= 1'b0;
    end else begin
      if (ram_en) begin
        if (accessQ.size() == 0) checkOutput("unexpected ram access", {23'd0, ram_we, ram_addr}, 32'h1FF);
        else checkOutput("ram we/addr", {23'd0, ram_we, ram_addr}, {23'd0, accessQ.pop_front()});
      end
      if (monitor_ready && !mrPrev) begin
        if (monQ.size() == 0) checkOutput("unexpected monitor_ready", 32'd1, 32'd0);
        else checkOutput("MonDReg", MonDReg, monQ.pop_front());
      end
      if (host_ack) begin
        if (hostQ.size() == 0) checkOutput("unexpected host_ack", 32'd1, 32'd0);
        else checkOutput("host_rdata", host_rdata, hostQ.pop_front());
      end
      mrPrev <= monitor_ready;
    end
  end

  task automatic applyStimulus(logic a, logic b, logic [37:0] j);
    @(posedge clk) #1;
    take_a = a; take_b = b; jdo = j;
    @(posedge clk) #1;
    take_a = 1'b0; take_b = 1'b0;
  endtask

  task automatic waitReady(string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (monitor_ready) done = 1'b1;
    end
    if (!done) checkOutput({tag, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitAck(string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (host_ack) done = 1'b1;
    end
    if (!done) checkOutput({tag, " ack timeout"}, 32'd0, 32'd1);
  endtask

  task automatic hostAccess(logic [7:0] addr);
    @(posedge clk) #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr;
    waitAck("host");
  endtask

  task automatic hostRelease();
    @(posedge clk) #1;
    host_req = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk) #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    monExp = '0;
  endtask

  task automatic expectRead(logic [7:0] addr, bit jtag);
    accessQ.push_back({1'b0, addr});
    if (jtag) begin
      monExp = refMem[addr];
      monQ.push_back(monExp);
    end else begin
      hostQ.push_back(refMem[addr]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = patt(i);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset MonDReg", MonDReg, 32'h0);
    checkOutput("reset host_rdata", host_rdata, 32'h0);
    checkOutput("reset monitor_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("reset jtag_ovf", {31'd0, jtag_ovf}, 32'd0);
    checkOutput("reset host_ack", {31'd0, host_ack}, 32'd0);
    checkOutput("reset ram_en/we", {30'd0, ram_en, ram_we}, 32'd0);

    $display("[TB] prefetch read at 0x10 and latency");
    expectRead(8'h10, 1'b1);
    applyStimulus(1'b1, 1'b0, jdoA(8'h10, 1'b1));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("latency ram_en N+%0d", c), {31'd0, ram_en}, {31'd0, c == 2});
      checkOutput($sformatf("latency ready N+%0d", c), {31'd0, monitor_ready}, {31'd0, c == 4});
    end
    expectRead(8'h11, 1'b1);
    applyStimulus(1'b0, 1'b1, jdoB(32'h0, 1'b0));
    waitReady("autoinc read");

    $display("[TB] write at 0xFF and address wrap");
    applyStimulus(1'b1, 1'b0, jdoA(8'hFF, 1'b0));
    accessQ.push_back({1'b1, 8'hFF});
    monQ.push_back(monExp);
    refMem[8'hFF] = 32'h12345678;
    applyStimulus(1'b0, 1'b1, jdoB(32'h12345678, 1'b1));
    waitReady("write");
    checkOutput("ram[0xFF] written", ram[8'hFF], refMem[8'hFF]);
    expectRead(8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, jdoB(32'h0, 1'b0));
    waitReady("wrap read");

    $display("[TB] JTAG wins the first tie after reset");
    doReset();
    expectRead(8'h20, 1'b1);
    expectRead(8'h05, 1'b0);
    @(posedge clk) #1;
    take_a = 1'b1; jdo = jdoA(8'h20, 1'b1);
    @(posedge clk) #1;
    take_a = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    waitAck("tie");
    checkOutput("JTAG done before host ack", {31'd0, monitor_ready}, 32'd1);
    hostRelease();

    $display("[TB] continuous host traffic against repeated JTAG reads");
    accessQ.push_back({1'b0, 8'h30}); hostQ.push_back(refMem[8'h30]);
    expectRead(8'h21, 1'b1);
    accessQ.push_back({1'b0, 8'h31}); hostQ.push_back(refMem[8'h31]);
    expectRead(8'h22, 1'b1);
    accessQ.push_back({1'b0, 8'h32}); hostQ.push_back(refMem[8'h32]);
    expectRead(8'h23, 1'b1);
    fork
      begin
        hostAccess(8'h30);
        hostAccess(8'h31);
        hostAccess(8'h32);
        hostRelease();
      end
      begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 1'b1, jdoB(32'h0, 1'b0));
          waitReady("alternate");
        end
      end
    join
    repeat (4) @(posedge clk);
    checkOutput("no overflow yet", {31'd0, jtag_ovf}, 32'd0);

    $display("[TB] overflow on strobe during in-flight read");
    expectRead(8'h24, 1'b1);
    applyStimulus(1'b0, 1'b1, jdoB(32'h0, 1'b0));
    applyStimulus(1'b0, 1'b1, jdoB(32'h0, 1'b0));
    waitReady("ovf read");
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("jtag_ovf sticky", {31'd0, jtag_ovf}, 32'd1);
    doReset();
    @(negedge clk);
    checkOutput("jtag_ovf cleared by reset", {31'd0, jtag_ovf}, 32'd0);
    expectRead(8'h40, 1'b1);
    applyStimulus(1'b1, 1'b1, jdoA(8'h40, 1'b1) | 38'h1);
    waitReady("a+b");
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("jtag_ovf a+b", {31'd0, jtag_ovf}, 32'd1);
    checkOutput("ram[0x40] untouched", ram[8'h40], refMem[8'h40]);

    $display("[TB] reset during host read CAPTURE");
    accessQ.push_back({1'b0, 8'h05});
    @(posedge clk) #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset_n = 1'b0; host_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort host_ack", {31'd0, host_ack}, 32'd0);
    checkOutput("abort ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("abort host_rdata", host_rdata, 32'h0);
    checkOutput("abort MonDReg", MonDReg, 32'h0);
    checkOutput("abort ready/ovf", {30'd0, monitor_ready, jtag_ovf}, 32'd0);
    @(posedge clk) #1;
    reset_n = 1'b1;
    monExp = '0;
    expectRead(8'h06, 1'b0);
    hostAccess(8'h06);
    hostRelease();
    repeat (4) @(posedge clk);

    checkOutput("access queue drained", accessQ.size(), 32'd0);
    checkOutput("MonDReg queue drained", monQ.size(), 32'd0);
    checkOutput("host queue drained", hostQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  // Hard time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
